// File: rtl/ahim_image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahim_image_ram_arbiter
// Purpose  : Single-port image RAM arbiter for RX writer, OCR fetcher and
//            HPS debug readback, with burst locking and starvation override.
// Revision : 1.0 - initial release
// ============================================================================
module ahim_image_ram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 65535,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  Clear_buff,
  input  logic                  rx_req,
  input  logic [ADDR_WIDTH-1:0] rx_addr,
  input  logic [DATA_WIDTH-1:0] rx_wdata,
  output logic                  rx_gnt,
  input  logic                  ocr_req,
  input  logic [ADDR_WIDTH-1:0] ocr_addr,
  output logic                  ocr_gnt,
  output logic                  ocr_rvalid,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            owner,
  output logic                  oor_error
);

  localparam int c_burst_w  = $clog2(MAX_BURST + 1);
  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_burst_w-1:0]  c_burst_last = c_burst_w'(MAX_BURST - 1);
  localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_RX  = 2'd1,
    OWN_OCR = 2'd2,
    OWN_DBG = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_burst_w-1:0]    r_burst;
  logic [c_starve_w-1:0]   r_starve;
  logic                    r_oor;
  logic                    r_ocr_rv;
  logic                    r_dbg_rv;
  logic                    r_rd_oor;

  logic [2:0]              w_req_vec;
  logic [2:0]              w_own_vec;
  logic [2:0]              w_others;
  logic [2:0]              w_cand;
  logic                    w_own_req;
  logic                    w_any_gnt;
  logic                    w_expire;
  logic                    w_starved;
  logic                    w_oor;
  logic [ADDR_WIDTH-1:0]   w_addr;

  // No grant may be issued in a flush cycle.
  assign rx_gnt  = (r_state == OWN_RX)  && rx_req  && !Clear_buff;
  assign ocr_gnt = (r_state == OWN_OCR) && ocr_req && !Clear_buff;
  assign dbg_gnt = (r_state == OWN_DBG) && dbg_req && !Clear_buff;

  assign w_any_gnt = rx_gnt || ocr_gnt || dbg_gnt;
  assign w_req_vec = {dbg_req, ocr_req, rx_req};
  assign w_addr    = rx_gnt  ? rx_addr  :
                     ocr_gnt ? ocr_addr :
                     dbg_gnt ? dbg_addr : '0;
  assign w_oor     = (32'(w_addr) >= 32'(RAM_DEPTH));
  assign w_expire  = w_any_gnt && (r_burst == c_burst_last);
  assign w_starved = (r_starve == c_starve_lim);
  assign w_others  = w_req_vec & ~w_own_vec;

  always_comb begin
    w_own_vec = 3'b000;
    w_own_req = 1'b0;
    case (r_state)
      OWN_RX:  begin w_own_vec = 3'b001; w_own_req = rx_req;  end
      OWN_OCR: begin w_own_vec = 3'b010; w_own_req = ocr_req; end
      OWN_DBG: begin w_own_vec = 3'b100; w_own_req = dbg_req; end
      default: begin w_own_vec = 3'b000; w_own_req = 1'b0;    end
    endcase
  end

  always_comb begin
    w_cand = w_req_vec;
    w_next = r_state;
    // At burst expiry the owner only keeps the RAM if nobody else is waiting.
    if (w_expire) begin
      w_cand = (w_others != 3'b000) ? w_others : w_own_vec;
    end
    if ((r_state == IDLE) || !w_own_req || w_expire) begin
      if (w_starved && w_cand[2]) w_next = OWN_DBG;
      else if (w_cand[0])         w_next = OWN_RX;
      else if (w_cand[1])         w_next = OWN_OCR;
      else if (w_cand[2])         w_next = OWN_DBG;
      else                        w_next = IDLE;
    end
    if (Clear_buff) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_burst  <= '0;
      r_starve <= '0;
      r_oor    <= 1'b0;
      r_ocr_rv <= 1'b0;
      r_dbg_rv <= 1'b0;
      r_rd_oor <= 1'b0;
    end else begin
      r_state <= w_next;

      if (Clear_buff || (w_next != r_state) || w_expire) r_burst <= '0;
      else if (w_any_gnt)                                  r_burst <= r_burst + 1'b1;

      if (Clear_buff || dbg_gnt)                                   r_starve <= '0;
      else if (dbg_req && (r_state != OWN_DBG) && !w_starved)      r_starve <= r_starve + 1'b1;

      r_ocr_rv <= ocr_gnt;
      r_dbg_rv <= dbg_gnt;
      r_rd_oor <= w_any_gnt && w_oor;

      if (Clear_buff)              r_oor <= 1'b0;
      else if (w_any_gnt && w_oor) r_oor <= 1'b1;
    end
  end

  // Reset gating keeps the write strobe low for the whole reset window.
  assign ram_we     = rx_gnt && !w_oor && rst_n;
  assign ram_addr   = w_addr;
  assign ram_wdata  = rx_wdata;
  assign owner      = r_state;
  assign oor_error  = r_oor;
  assign ocr_rvalid = r_ocr_rv;
  assign dbg_rvalid = r_dbg_rv;
  assign rdata      = ((r_ocr_rv || r_dbg_rv) && !r_rd_oor) ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahim_image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahim_image_ram_arbiter
// Purpose  : Randomized self-checking bench for ahim_image_ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahim_image_ram_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 65535;
  localparam int MB    = 16;
  localparam int SL    = 64;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          Clear_buff = 1'b0;
  logic          rx_req = 1'b0, ocr_req = 1'b0, dbg_req = 1'b0;
  logic [AW-1:0] rx_addr = '0, ocr_addr = '0, dbg_addr = '0;
  logic [DW-1:0] rx_wdata = '0;
  logic          rx_gnt, ocr_gnt, dbg_gnt, ocr_rvalid, dbg_rvalid, ram_we, oor_error;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    owner;

  ahim_image_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH),
    .MAX_BURST(MB), .STARVE_LIMIT(SL)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .Clear_buff(Clear_buff),
    .rx_req(rx_req), .rx_addr(rx_addr), .rx_wdata(rx_wdata), .rx_gnt(rx_gnt),
    .ocr_req(ocr_req), .ocr_addr(ocr_addr), .ocr_gnt(ocr_gnt), .ocr_rvalid(ocr_rvalid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .owner(owner), .oor_error(oor_error)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk_in) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state
  logic [DW-1:0] sh [0:65535];
  int            m_owner, m_burst, m_starve;
  logic          m_oor, m_rv_ocr, m_rv_dbg;
  logic [DW-1:0] m_rd;
  logic          last_rx_gnt;
  int            fill_idx;

  task automatic model_reset();
    m_owner = 0; m_burst = 0; m_starve = 0;
    m_oor = 1'b0; m_rv_ocr = 1'b0; m_rv_dbg = 1'b0; m_rd = '0;
  endtask

  // One clock: called at a falling edge with inputs already applied.
  task automatic step();
    logic          e_rx, e_ocr, e_dbg, e_we, e_acc, granted, expiry;
    logic [AW-1:0] e_addr;
    logic [3:0]    req, pool;
    int            new_owner;
    #2;
    e_rx   = (m_owner == 1) && rx_req  && !Clear_buff;
    e_ocr  = (m_owner == 2) && ocr_req && !Clear_buff;
    e_dbg  = (m_owner == 3) && dbg_req && !Clear_buff;
    granted = e_rx || e_ocr || e_dbg;
    e_addr = e_rx ? rx_addr : e_ocr ? ocr_addr : e_dbg ? dbg_addr : '0;
    e_acc  = granted && (int'(e_addr) >= DEPTH);
    e_we   = e_rx && !e_acc;
    check_value("rx_gnt", rx_gnt, e_rx);
    check_value("ocr_gnt", ocr_gnt, e_ocr);
    check_value("dbg_gnt", dbg_gnt, e_dbg);
    check_value("ram_we", ram_we, e_we);
    check_value("ram_addr", ram_addr, e_addr);
    check_value("ram_wdata", ram_wdata, rx_wdata);
    check_value("owner", owner, m_owner[1:0]);
    check_value("ocr_rvalid", ocr_rvalid, m_rv_ocr);
    check_value("dbg_rvalid", dbg_rvalid, m_rv_dbg);
    check_value("oor_error", oor_error, m_oor);
    if (m_rv_ocr || m_rv_dbg) check_value("rdata", rdata, m_rd);
    last_rx_gnt = e_rx;

    @(posedge clk_in);
    req = {dbg_req, ocr_req, rx_req, 1'b0};
    if (Clear_buff) begin
      m_rv_ocr = 1'b0; m_rv_dbg = 1'b0;
      m_oor = 1'b0;
      model_reset();
    end else begin
      m_rv_ocr = e_ocr;
      m_rv_dbg = e_dbg;
      if (e_ocr || e_dbg) m_rd = e_acc ? '0 : sh[e_addr];
      if (e_we) sh[e_addr] = rx_wdata;
      if (e_acc) m_oor = 1'b1;
      expiry = granted && (m_burst == MB - 1);
      new_owner = m_owner;
      if (m_owner == 0 || !req[m_owner] || expiry) begin
        pool = req;
        if (expiry) pool[m_owner] = 1'b0;
        if (expiry && pool == 4'b0000) new_owner = m_owner;
        else if (m_starve == SL && pool[3]) new_owner = 3;
        else if (pool[1]) new_owner = 1;
        else if (pool[2]) new_owner = 2;
        else if (pool[3]) new_owner = 3;
        else new_owner = 0;
      end
      if (e_dbg) m_starve = 0;
      else if (dbg_req && m_owner != 3 && m_starve < SL) m_starve++;
      if (new_owner != m_owner || expiry) m_burst = 0;
      else if (granted) m_burst++;
      m_owner = new_owner;
    end
    @(negedge clk_in);
  endtask

  task automatic drive_random(input int p_rx, input int p_ocr, input int p_dbg, input int p_clr, input int p_oor);
    rx_req     = ($urandom_range(99) < p_rx);
    ocr_req    = ($urandom_range(99) < p_ocr);
    dbg_req    = ($urandom_range(99) < p_dbg);
    Clear_buff = ($urandom_range(99) < p_clr);
    rx_addr    = ($urandom_range(99) < p_oor) ? 16'hFFFF : 16'($urandom_range(255));
    ocr_addr   = ($urandom_range(99) < p_oor) ? 16'hFFFF : 16'($urandom_range(255));
    dbg_addr   = ($urandom_range(99) < p_oor) ? 16'hFFFF : 16'($urandom_range(255));
    rx_wdata   = 8'($urandom_range(255));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_rx_gnt"}, rx_gnt, 1'b0);
    check_value({tag, "_ram_we"}, ram_we, 1'b0);
    check_value({tag, "_owner"}, owner, 2'd0);
    check_value({tag, "_ocr_rvalid"}, ocr_rvalid, 1'b0);
    check_value({tag, "_dbg_rvalid"}, dbg_rvalid, 1'b0);
    check_value({tag, "_oor"}, oor_error, 1'b0);
  endtask

  initial begin
    model_reset();
    last_rx_gnt = 1'b0;
    // Reset state, with a request pending that must not be granted.
    rx_req = 1'b1;
    repeat (2) @(negedge clk_in);
    #2;
    check_idle_outputs("reset");
    check_value("reset_ram_addr", ram_addr, '0);
    rx_req = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;

    // Fill low memory through the arbiter so later reads are defined.
    rx_req = 1'b1;
    fill_idx = 0;
    for (int k = 0; k < 600 && fill_idx < 256; k++) begin
      rx_addr  = 16'(fill_idx);
      rx_wdata = 8'($urandom_range(255));
      step();
      if (last_rx_gnt) fill_idx++;
    end
    check_value("fill_done", fill_idx, 256);

    for (int c = 0; c < 400; c++) begin drive_random(60, 60, 30, 2, 5); step(); end
    for (int c = 0; c < 400; c++) begin drive_random(100, 100, 100, 0, 3); step(); end
    for (int c = 0; c < 300; c++) begin drive_random(90, 90, 50, 1, 5); step(); end

    // Asynchronous reset in the middle of an RX burst.
    Clear_buff = 1'b0; ocr_req = 1'b0; dbg_req = 1'b0; rx_req = 1'b1;
    for (int c = 0; c < 6; c++) begin rx_addr = 16'(c); rx_wdata = 8'(c); step(); end
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    model_reset();
    @(negedge clk_in);
    rx_req = 1'b0;
    rst_n  = 1'b1;
    repeat (2) step();
    rx_req = 1'b1;
    repeat (3) step();

    for (int c = 0; c < 300; c++) begin drive_random(70, 70, 70, 2, 5); step(); end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
